// File: rtl/complex_butterfly_dif_iter_3_clk_cycles_pkg.sv
// Shared definitions for the time-shared DIF butterfly: phase encoding and width helpers.
package complex_butterfly_dif_iter_3_clk_cycles_pkg;

  typedef enum logic [1:0] {
    PH_P0   = 2'd0,
    PH_P1   = 2'd1,
    PH_P2   = 2'd2,
    PH_IDLE = 2'd3
  } phase_t;

  // Full-precision signed product width.
  function automatic int unsigned prod_width(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/complex_butterfly_dif_iter_3_clk_cycles_if.sv
// Operand/result bundle of the DIF butterfly; master drives operands, slave returns results.
interface complex_butterfly_dif_iter_3_clk_cycles_if #(
  parameter int unsigned IWL1 = 16,
  parameter int unsigned IWL2 = 16,
  parameter int unsigned OWL  = 16
);
  logic                   strb_in;
  logic signed [IWL1-1:0] dina_re;
  logic signed [IWL1-1:0] dina_im;
  logic signed [IWL1-1:0] dinb_re;
  logic signed [IWL1-1:0] dinb_im;
  logic signed [IWL2-1:0] tw_re;
  logic signed [IWL2-1:0] tw_im;
  logic signed [OWL-1:0]  dout1_re;
  logic signed [OWL-1:0]  dout1_im;
  logic signed [OWL-1:0]  dout2_re;
  logic signed [OWL-1:0]  dout2_im;
  logic                   strb_out;

  modport master (
    output strb_in, dina_re, dina_im, dinb_re, dinb_im, tw_re, tw_im,
    input  dout1_re, dout1_im, dout2_re, dout2_im, strb_out
  );

  modport slave (
    input  strb_in, dina_re, dina_im, dinb_re, dinb_im, tw_re, tw_im,
    output dout1_re, dout1_im, dout2_re, dout2_im, strb_out
  );
endinterface

// File: rtl/complex_butterfly_dif_iter_3_clk_cycles_cplx_round_sat.sv
// Arithmetic right shift with round-half-up, then saturation to OW bits (combinational).
module complex_butterfly_dif_iter_3_clk_cycles_cplx_round_sat #(
  parameter int unsigned IW    = 17,
  parameter int unsigned SHIFT = 1,
  parameter int unsigned OW    = 16
) (
  input  logic signed [IW-1:0] x,
  output logic signed [OW-1:0] q_c
);
  // One guard bit so adding the rounding half can never wrap.
  localparam int unsigned EW = IW + 1;
  localparam logic signed [EW-1:0] MAXV = EW'((64'(1) << (OW - 1)) - 64'(1));
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rnd;

  assign ext = EW'(x);

  generate
    if (SHIFT == 0) begin : g_no_rnd
      assign rnd = ext;
    end else begin : g_rnd
      localparam logic signed [EW-1:0] HALF = EW'(64'(1) << (SHIFT - 1));
      assign rnd = (ext + HALF) >>> SHIFT;
    end
  endgenerate

  always_comb begin
    q_c = OW'(rnd);
    if (rnd > MAXV)      q_c = OW'(MAXV);
    else if (rnd < MINV) q_c = OW'(MINV);
  end

endmodule

// File: rtl/complex_butterfly_dif_iter_3_clk_cycles.sv
// Radix-2 DIF butterfly: dout1 = A+B, dout2 = (A-B)*W, two multipliers shared over three phases.
module complex_butterfly_dif_iter_3_clk_cycles
  import complex_butterfly_dif_iter_3_clk_cycles_pkg::*;
#(
  parameter int unsigned IWL1           = 16,
  parameter int unsigned IWL2           = 16,
  parameter int unsigned OWL            = 16,
  parameter int unsigned CONSTANT_SHIFT = 1
) (
  input logic clk,
  input logic rst,
  complex_butterfly_dif_iter_3_clk_cycles_if.slave bus
);
  localparam int unsigned DW  = IWL1 + 1;
  localparam int unsigned PW  = prod_width(DW, IWL2);
  localparam int unsigned SW  = PW + 1;
  localparam int unsigned SH2 = IWL2 - 1 + CONSTANT_SHIFT;

  phase_t phase, phase_nxt;
  logic   load_sd, load_p, load_out;

  logic signed [IWL1-1:0] a_re, a_im, b_re, b_im;
  logic signed [IWL2-1:0] w_re, w_im;
  logic signed [DW-1:0]   s_re, s_im, d_re, d_im;
  logic signed [PW-1:0]   p_rr, p_ii;

  logic signed [SW-1:0]   add_l, add_r, sub_l, sub_r, add_o, sub_o;
  logic signed [DW-1:0]   add_im_o, sub_im_o;
  logic signed [DW-1:0]   mx0, mx1;
  logic signed [IWL2-1:0] my0, my1;
  logic signed [PW-1:0]   m0, m1;
  logic signed [OWL-1:0]  q1_re_c, q1_im_c, q2_re_c, q2_im_c;

  // Phase sequencing; a new strobe always restarts at P0.
  always_comb begin
    phase_nxt = phase;
    load_sd   = 1'b0;
    load_p    = 1'b0;
    load_out  = 1'b0;
    case (phase)
      PH_P0:   begin phase_nxt = PH_P1;   load_sd  = 1'b1; end
      PH_P1:   begin phase_nxt = PH_P2;   load_p   = 1'b1; end
      PH_P2:   begin phase_nxt = PH_IDLE; load_out = 1'b1; end
      default: phase_nxt = PH_IDLE;
    endcase
    if (bus.strb_in) phase_nxt = PH_P0;
  end

  // Real add/sub pair serves A+-B in P0 and the product combine in P2.
  always_comb begin
    add_l = SW'(a_re);
    add_r = SW'(b_re);
    sub_l = SW'(a_re);
    sub_r = SW'(b_re);
    mx0   = d_re;
    my0   = w_re;
    mx1   = d_im;
    my1   = w_im;
    if (phase == PH_P2) begin
      add_l = SW'(m0);
      add_r = SW'(m1);
      sub_l = SW'(p_rr);
      sub_r = SW'(p_ii);
      my0   = w_im;
      my1   = w_re;
    end
  end

  assign add_o    = add_l + add_r;
  assign sub_o    = sub_l - sub_r;
  assign add_im_o = DW'(a_im) + DW'(b_im);
  assign sub_im_o = DW'(a_im) - DW'(b_im);
  assign m0       = PW'(mx0) * PW'(my0);
  assign m1       = PW'(mx1) * PW'(my1);

  complex_butterfly_dif_iter_3_clk_cycles_cplx_round_sat #(.IW(DW), .SHIFT(CONSTANT_SHIFT), .OW(OWL))
    u_rs1_re (.x(s_re), .q_c(q1_re_c));
  complex_butterfly_dif_iter_3_clk_cycles_cplx_round_sat #(.IW(DW), .SHIFT(CONSTANT_SHIFT), .OW(OWL))
    u_rs1_im (.x(s_im), .q_c(q1_im_c));
  complex_butterfly_dif_iter_3_clk_cycles_cplx_round_sat #(.IW(SW), .SHIFT(SH2), .OW(OWL))
    u_rs2_re (.x(sub_o), .q_c(q2_re_c));
  complex_butterfly_dif_iter_3_clk_cycles_cplx_round_sat #(.IW(SW), .SHIFT(SH2), .OW(OWL))
    u_rs2_im (.x(add_o), .q_c(q2_im_c));

  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= PH_IDLE;
      a_re         <= '0;
      a_im         <= '0;
      b_re         <= '0;
      b_im         <= '0;
      w_re         <= '0;
      w_im         <= '0;
      s_re         <= '0;
      s_im         <= '0;
      d_re         <= '0;
      d_im         <= '0;
      p_rr         <= '0;
      p_ii         <= '0;
      bus.dout1_re <= '0;
      bus.dout1_im <= '0;
      bus.dout2_re <= '0;
      bus.dout2_im <= '0;
      bus.strb_out <= 1'b0;
    end else begin
      phase <= phase_nxt;
      if (bus.strb_in) begin
        a_re <= bus.dina_re;
        a_im <= bus.dina_im;
        b_re <= bus.dinb_re;
        b_im <= bus.dinb_im;
        w_re <= bus.tw_re;
        w_im <= bus.tw_im;
      end
      if (load_sd) begin
        s_re <= DW'(add_o);
        s_im <= add_im_o;
        d_re <= DW'(sub_o);
        d_im <= sub_im_o;
      end
      if (load_p) begin
        p_rr <= m0;
        p_ii <= m1;
      end
      // Results commit at the end of P2 even if a new strobe arrives on that edge.
      if (load_out) begin
        bus.dout1_re <= q1_re_c;
        bus.dout1_im <= q1_im_c;
        bus.dout2_re <= q2_re_c;
        bus.dout2_im <= q2_im_c;
      end
      bus.strb_out <= load_out;
    end
  end

endmodule

// File: tb/tb_complex_butterfly_dif_iter_3_clk_cycles.sv
// Directed bench for the DIF butterfly with a scaled (CS=1) and an unscaled (CS=0) instance.
module tb_complex_butterfly_dif_iter_3_clk_cycles;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  logic [63:0] exp1 [8];
  logic [63:0] exp0 [8];
  logic [63:0] e1, e0;
  logic signed [15:0] v [6];

  always #5 clk = ~clk;

  complex_butterfly_dif_iter_3_clk_cycles_if bus1 ();
  complex_butterfly_dif_iter_3_clk_cycles_if bus0 ();

  complex_butterfly_dif_iter_3_clk_cycles #(.CONSTANT_SHIFT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  complex_butterfly_dif_iter_3_clk_cycles #(.CONSTANT_SHIFT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  function automatic logic [15:0] rs(input longint x, input int n);
    longint r;
    r = (n == 0) ? x : ((x + (longint'(1) <<< (n - 1))) >>> n);
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  function automatic logic [63:0] model(input int cs, input logic signed [15:0] ar, ai, br, bi, wr, wi);
    longint sre, sim, dre, dim, pre, pim;
    sre = longint'(ar) + longint'(br);
    sim = longint'(ai) + longint'(bi);
    dre = longint'(ar) - longint'(br);
    dim = longint'(ai) - longint'(bi);
    pre = dre * longint'(wr) - dim * longint'(wi);
    pim = dre * longint'(wi) + dim * longint'(wr);
    return {rs(sre, cs), rs(sim, cs), rs(pre, 15 + cs), rs(pim, 15 + cs)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int cs, input logic stb, input logic [63:0] exp);
    logic [63:0] got;
    logic        gs;
    if (cs == 1) begin
      got = {bus1.dout1_re, bus1.dout1_im, bus1.dout2_re, bus1.dout2_im};
      gs  = bus1.strb_out;
    end else begin
      got = {bus0.dout1_re, bus0.dout1_im, bus0.dout2_re, bus0.dout2_im};
      gs  = bus0.strb_out;
    end
    chk({tag, "_strb"},  32'(gs), 32'(stb));
    chk({tag, "_d1re"}, 32'(got[63:48]), 32'(exp[63:48]));
    chk({tag, "_d1im"}, 32'(got[47:32]), 32'(exp[47:32]));
    chk({tag, "_d2re"}, 32'(got[31:16]), 32'(exp[31:16]));
    chk({tag, "_d2im"}, 32'(got[15:0]),  32'(exp[15:0]));
  endtask

  task automatic drive(input logic s, input logic signed [15:0] ar, ai, br, bi, wr, wi);
    bus1.strb_in = s; bus1.dina_re = ar; bus1.dina_im = ai; bus1.dinb_re = br;
    bus1.dinb_im = bi; bus1.tw_re = wr; bus1.tw_im = wi;
    bus0.strb_in = s; bus0.dina_re = ar; bus0.dina_im = ai; bus0.dinb_re = br;
    bus0.dinb_im = bi; bus0.tw_re = wr; bus0.tw_im = wi;
  endtask

  // Strobe low with scrambled operands, which must be ignored after capture.
  task automatic idle();
    drive(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic bf(input string tag, input int cs, input logic signed [15:0] ar, ai, br, bi, wr, wi,
                    input logic [63:0] exp);
    logic gs;
    @(negedge clk); drive(1'b1, ar, ai, br, bi, wr, wi);
    @(negedge clk); idle();
    @(negedge clk);
    @(negedge clk);
    gs = (cs == 1) ? bus1.strb_out : bus0.strb_out;
    chk({tag, "_early"}, 32'(gs), 32'(0));
    @(negedge clk);
    chk_outs(tag, cs, 1'b1, exp);
    @(negedge clk);
    gs = (cs == 1) ? bus1.strb_out : bus0.strb_out;
    chk({tag, "_pulse_end"}, 32'(gs), 32'(0));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk_outs("reset1", 1, 1'b0, 64'h0);
    chk_outs("reset0", 0, 1'b0, 64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_strb", 32'(bus1.strb_out), 32'(0));

    bf("t1", 1, 16'h2000, 16'h0, 16'h1000, 16'h0, 16'h7FFF, 16'h0, {16'h1800, 16'h0, 16'h0800, 16'h0});
    bf("t2", 1, 16'h2000, 16'h0, 16'h1000, 16'h0, 16'h0, 16'h7FFF, {16'h1800, 16'h0, 16'h0, 16'h0800});
    bf("t3", 0, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0, {16'h7FFF, 16'h8000, 16'h0, 16'h0});
    bf("t4", 0, 16'h7FFF, 16'h0, 16'h8000, 16'h0, 16'h8000, 16'h0, {16'hFFFF, 16'h0, 16'h8000, 16'h0});

    // Back-to-back starts every third edge; each result lands on the next start's edge.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pulses += int'(bus1.strb_out);
      if (i < 8) begin
        for (int j = 0; j < 6; j++) v[j] = 16'($urandom);
        exp1[i] = model(1, v[0], v[1], v[2], v[3], v[4], v[5]);
        exp0[i] = model(0, v[0], v[1], v[2], v[3], v[4], v[5]);
        drive(1'b1, v[0], v[1], v[2], v[3], v[4], v[5]);
      end else begin
        idle();
      end
      @(negedge clk);
      pulses += int'(bus1.strb_out);
      idle();
      if (i > 0) begin
        chk_outs("b2b1", 1, 1'b1, exp1[i-1]);
        chk_outs("b2b0", 0, 1'b1, exp0[i-1]);
      end
      @(negedge clk);
      pulses += int'(bus1.strb_out);
    end
    chk("b2b_pulses", 32'(pulses), 32'(8));

    // A restart during P0 drops the first butterfly.
    for (int j = 0; j < 6; j++) v[j] = 16'($urandom);
    @(negedge clk); drive(1'b1, v[0], v[1], v[2], v[3], v[4], v[5]);
    @(negedge clk); drive(1'b1, 16'h2000, 16'h0, 16'h1000, 16'h0, 16'h7FFF, 16'h0);
    e0 = model(0, 16'h2000, 16'h0, 16'h1000, 16'h0, 16'h7FFF, 16'h0);
    @(negedge clk); idle();
    @(negedge clk);
    @(negedge clk);
    chk_outs("abort1", 1, 1'b0, exp1[7]);
    chk_outs("abort0", 0, 1'b0, exp0[7]);
    @(negedge clk);
    e1 = {16'h1800, 16'h0, 16'h0800, 16'h0};
    chk_outs("restart1", 1, 1'b1, e1);
    chk_outs("restart0", 0, 1'b1, e0);

    // Reset applied while the butterfly is in P1.
    @(negedge clk); drive(1'b1, 16'h1234, 16'h0567, 16'h0F00, 16'h0100, 16'h4000, 16'h2000);
    @(negedge clk); idle();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk_outs("rst_mid1", 1, 1'b0, 64'h0);
    chk_outs("rst_mid0", 0, 1'b0, 64'h0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_strb", 32'(bus1.strb_out | bus0.strb_out), 32'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
